// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory, and queues {pc, instr} pairs in a 2-entry buffer for decode.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; no fetch, redirect ignored
// FETCH | pushing one instruction per cycle while the buffer has room
// HALT  | walked past the last word; no fetch, buffer drains to decode
// FAULT | redirect to a misaligned/out-of-range target; sticky until reset
module inst_fetch_ctrl #(
    parameter int MEM_BYTES = 16,
    parameter int RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [63:0] LAST_PC  = 64'(MEM_BYTES - 4);
    localparam logic [63:0] START_PC = 64'(RESET_PC);

    state_t      state_q;
    state_t      state_d;

    logic [63:0] pc_q;
    logic [1:0]  count_q;

    // Entry 0 doubles as the output register so the head holds its last
    // value once the buffer empties; entry 1 is the second slot.
    logic [31:0] head_instr_q;
    logic [63:0] head_pc_q;
    logic [31:0] tail_instr_q;
    logic [63:0] tail_pc_q;
    logic [31:0] inst_count_q;

    logic        fetch_en;
    logic        flush_en;
    logic        push;
    logic        pop;
    logic [63:0] pc_plus4;
    logic        halt_hit;
    logic        bad_target;

    assign mem_addr   = pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst_out   = head_instr_q;
    assign inst_pc    = head_pc_q;
    assign inst_count = inst_count_q;

    assign pc_plus4   = pc_q + 64'd4;
    assign halt_hit   = (pc_plus4 > LAST_PC);
    // Unsigned compare: targets near 2^64 fault instead of aliasing.
    assign bad_target = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);

    assign pop  = inst_valid && inst_ready;
    assign push = fetch_en && !redirect &&
                  ((count_q != 2'd2) || pop);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks the end-of-memory halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (redirect)      state_d = bad_target ? FAULT : FETCH;
                else if (push && halt_hit) state_d = HALT;
            end
            HALT: begin
                if (redirect) state_d = bad_target ? FAULT : FETCH;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls and status outputs.
    always_comb begin
        fetch_en = (state_q == FETCH);
        flush_en = redirect && ((state_q == FETCH) || (state_q == HALT));
        halted   = (state_q == HALT);
        fault    = (state_q == FAULT);
    end

    // PC, 2-entry buffer and delivered-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= START_PC;
            count_q      <= 2'd0;
            head_instr_q <= 32'd0;
            head_pc_q    <= 64'd0;
            tail_instr_q <= 32'd0;
            tail_pc_q    <= 64'd0;
            inst_count_q <= 32'd0;
        end else begin
            if (pop) inst_count_q <= inst_count_q + 32'd1;

            if (flush_en) begin
                pc_q    <= redirect_pc;
                count_q <= 2'd0;
            end else begin
                if (push) pc_q <= pc_plus4;
                case ({push, pop})
                    2'b10: begin
                        if (count_q == 2'd0) begin
                            head_instr_q <= mem_instr;
                            head_pc_q    <= pc_q;
                        end else begin
                            tail_instr_q <= mem_instr;
                            tail_pc_q    <= pc_q;
                        end
                        count_q <= count_q + 2'd1;
                    end
                    2'b01: begin
                        if (count_q == 2'd2) begin
                            head_instr_q <= tail_instr_q;
                            head_pc_q    <= tail_pc_q;
                        end
                        count_q <= count_q - 2'd1;
                    end
                    2'b11: begin
                        if (count_q == 2'd1) begin
                            head_instr_q <= mem_instr;
                            head_pc_q    <= pc_q;
                        end else begin
                            head_instr_q <= tail_instr_q;
                            head_pc_q    <= tail_pc_q;
                            tail_instr_q <= mem_instr;
                            tail_pc_q    <= pc_q;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a {pc, instr} scoreboard.
module tb_inst_fetch_ctrl;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] mem_addr;
    logic [31:0] mem_instr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] inst_count;

    logic [31:0] words [4];
    entry_t      exp_q [$];
    int          n_tests;
    int          n_fail;

    inst_fetch_ctrl #(.MEM_BYTES(16), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_instr  (mem_instr),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted),
        .fault      (fault),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_instr = (mem_addr < 64'd16) ? words[mem_addr[3:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc);
        entry_t e;
        e.pc    = pc;
        e.instr = words[pc[3:2]];
        exp_q.push_back(e);
    endtask

    // One clock: score any handshake at the negedge, then step past the posedge.
    task automatic cycle();
        entry_t e;
        @(negedge clk);
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_instr", 64'(inst_out), 64'(e.instr));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        start    = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        words[0] = 32'h0285_3483;
        words[1] = 32'h009A_84B3;
        words[2] = 32'h0014_8493;
        words[3] = 32'h0295_3423;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b0;
        #12;

        // Reset values
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_out", 64'(inst_out), 64'd0);
        chk("rst_pc", inst_pc, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_count", 64'(inst_count), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with decode always ready
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(64'(i * 4));
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t1_valid_at_fetch", 64'(inst_valid), 64'd0);
        cycle();
        chk("t1_valid_rise", 64'(inst_valid), 64'd1);
        chk("t1_first_pc", inst_pc, 64'd0);
        cycle(); cycle(); cycle();
        chk("t1_count_mid", 64'(inst_count), 64'd3);
        chk("t1_halted", 64'(halted), 64'd1);
        chk("t1_pc_past_end", mem_addr, 64'd16);
        cycle();
        chk("t1_drained", 64'(inst_valid), 64'd0);
        chk("t1_count", 64'(inst_count), 64'd4);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Redirect out of HALT resumes fetching
        redirect = 1'b1; redirect_pc = 64'd0;
        for (int i = 0; i < 4; i++) push_exp(64'(i * 4));
        cycle();
        redirect = 1'b0;
        chk("t4_halted_clr", 64'(halted), 64'd0);
        chk("t4_valid_flush", 64'(inst_valid), 64'd0);
        chk("t4_mem_addr", mem_addr, 64'd0);
        cycle();
        chk("t4_valid", 64'(inst_valid), 64'd1);
        cycle();
        chk("t4_count5", 64'(inst_count), 64'd5);
        cycle(); cycle(); cycle();
        chk("t4_count8", 64'(inst_count), 64'd8);
        chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_halted", 64'(halted), 64'd1);

        // Backpressure: buffer fills to 2 and head holds
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(64'(i * 4));
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle(); cycle();
        chk("t2_valid", 64'(inst_valid), 64'd1);
        chk("t2_head_pc", inst_pc, 64'd0);
        cycle(); cycle(); cycle();
        chk("t2_hold_pc", inst_pc, 64'd0);
        chk("t2_hold_instr", 64'(inst_out), 64'h0285_3483);
        chk("t2_fetch_stall", mem_addr, 64'd8);
        chk("t2_no_pop", 64'(inst_count), 64'd0);
        inst_ready = 1'b1;
        cycle(); cycle(); cycle(); cycle();
        chk("t2_count", 64'(inst_count), 64'd4);
        chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t2_valid_end", 64'(inst_valid), 64'd0);

        // Redirect with buffer holding PCs 8 and 12, head popped that cycle
        do_reset();
        inst_ready = 1'b0;
        push_exp(64'd0); push_exp(64'd4); push_exp(64'd8);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle(); cycle();
        inst_ready = 1'b1;
        cycle(); cycle();
        chk("t3_head8", inst_pc, 64'd8);
        redirect = 1'b1; redirect_pc = 64'd4;
        push_exp(64'd4); push_exp(64'd8); push_exp(64'd12);
        cycle();
        redirect = 1'b0;
        chk("t3_flush", 64'(inst_valid), 64'd0);
        chk("t3_pop_counted", 64'(inst_count), 64'd3);
        cycle(); cycle(); cycle(); cycle();
        chk("t3_count", 64'(inst_count), 64'd6);
        chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Misaligned redirect faults; later start/redirect ignored
        redirect = 1'b1; redirect_pc = 64'd6;
        cycle();
        redirect = 1'b0;
        chk("t5_fault_misal", 64'(fault), 64'd1);
        chk("t5_valid", 64'(inst_valid), 64'd0);
        chk("t5_pc", mem_addr, 64'd6);
        start = 1'b1; redirect = 1'b1; redirect_pc = 64'd0;
        cycle(); cycle();
        start = 1'b0; redirect = 1'b0;
        chk("t5_sticky", 64'(fault), 64'd1);
        chk("t5_no_fetch", mem_addr, 64'd6);
        chk("t5_count_frozen", 64'(inst_count), 64'd6);
        do_reset();
        chk("t5_fault_clr", 64'(fault), 64'd0);

        // Out-of-range redirect while fetching
        inst_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        redirect = 1'b1; redirect_pc = 64'd16;
        cycle();
        redirect = 1'b0;
        chk("t5_fault_range", 64'(fault), 64'd1);
        chk("t5_range_valid", 64'(inst_valid), 64'd0);
        cycle();
        chk("t5_range_pc", mem_addr, 64'd16);
        chk("t5_range_count", 64'(inst_count), 64'd0);

        // Target near 2^64 must not wrap into range
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect = 1'b0;
        chk("t5_fault_wrap", 64'(fault), 64'd1);

        // Asynchronous reset mid-stream
        do_reset();
        inst_ready = 1'b0;
        push_exp(64'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("t6_pre_count", 64'(inst_count), 64'd1);
        chk("t6_pre_valid", 64'(inst_valid), 64'd1);
        chk("t6_pre_pc", inst_pc, 64'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 64'(inst_valid), 64'd0);
        chk("t6_out", 64'(inst_out), 64'd0);
        chk("t6_pc", inst_pc, 64'd0);
        chk("t6_count", 64'(inst_count), 64'd0);
        chk("t6_mem_addr", mem_addr, 64'd0);
        chk("t6_halted", 64'(halted), 64'd0);
        chk("t6_fault", 64'(fault), 64'd0);
        chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch sequencer for the byte-addressed, combinational-read instruction memory.
- Owns the program counter and drives the memory address.
- Captures each 32-bit instruction with its PC into a 2-entry buffer and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects, end-of-memory halt, bad-target fault, and a delivered-instruction counter.

Parameters:
- MEM_BYTES, 16, instruction memory size in bytes; must be a multiple of 4 and at least 4.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned and at most MEM_BYTES-4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins fetching from IDLE.
- mem_addr  output  64  address to instruction memory.
- mem_instr  input  32  instruction returned combinationally for mem_addr.
- inst_valid  output  1  buffer head holds a valid instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_out  output  32  head instruction.
- inst_pc  output  64  PC of the head instruction.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  64  new fetch address.
- halted  output  1  state is HALT.
- fault  output  1  state is FAULT (sticky).
- inst_count  output  32  number of completed handshakes, wrapping.

Behaviour:
- Reset (reset=0, takes effect immediately):
  - state=IDLE, pc=RESET_PC, buffer empty.
  - inst_valid=0, inst_out=0, inst_pc=0, halted=0, fault=0, inst_count=0.
- mem_addr = pc, combinational, in every state.
- States and transitions:
  - IDLE: no fetch; redirect ignored. start=1 moves to FETCH next cycle.
  - FETCH: fetch as below.
  - HALT: no fetch; the buffer keeps draining to decode.
  - FAULT: no fetch; buffer empty; leaves only on reset.
- start is ignored outside IDLE.
- Fetch, in FETCH with no redirect: a push occurs when buffer count < 2, or count = 2 and the head is popped in the same cycle.
  - A push writes {pc, mem_instr} at the tail and sets pc <= pc+4.
  - If pc+4 > MEM_BYTES-4, the state becomes HALT. pc still advances and the last instruction is still pushed.
- Pop: inst_valid & inst_ready. The head is removed and inst_count increments, wrapping 0xFFFFFFFF to 0.
- Simultaneous push and pop keep the count unchanged and preserve order.
- Output stability: while inst_valid=1 and inst_ready=0, inst_out and inst_pc hold steady.
  - inst_valid=1 exactly when count > 0.
  - When the buffer is empty, inst_out and inst_pc hold their last value.
- Latency:
  - start pulse at edge N puts the state in FETCH.
  - The first push happens at edge N+1, so inst_valid is high after edge N+1.
  - With inst_ready held at 1, one instruction is delivered per cycle.
- Redirect, in FETCH or HALT: redirect has priority over push.
  - Buffer is cleared at the edge, so inst_valid=0 the next cycle.
  - A pop in the same cycle still counts as delivered, and inst_count increments.
  - pc <= redirect_pc.
  - If redirect_pc[1:0] != 0 or redirect_pc > MEM_BYTES-4, the state becomes FAULT. Otherwise the state becomes FETCH, which resumes from HALT.
- Redirect is ignored in IDLE and FAULT.
- fault=1 is held until reset. inst_count freezes in FAULT.
- Reset asserted mid-operation discards buffer contents at once with no handshake completion.
- Address arithmetic is full 64-bit unsigned. The bounds compare is unsigned, so a redirect_pc near 2^64 faults with no wrap alias.

Test Plan:
Bench memory, little-endian, MEM_BYTES=16: word 0 = 0x02853483, word 4 = 0x009A84B3, word 8 = 0x00148493, word 12 = 0x02953423.
1. Reset, start pulse, inst_ready=1 -> inst_valid rises 2 cycles after start. Pairs (0,0x02853483), (4,0x009A84B3), (8,0x00148493), (12,0x02953423) arrive on consecutive cycles. halted=1 after the 4th push. inst_count=4. inst_valid=0 afterwards.
2. inst_ready=0 for 5 cycles after start -> count stays at 2 with head (0,0x02853483) stable. Raising inst_ready gives all 4 words in order, none lost or duplicated.
3. Redirect to 4 while the buffer holds PCs 8 and 12 -> next-cycle inst_valid=0. Then (4,0x009A84B3), (8,0x00148493), (12,0x02953423). A same-cycle pop of the head at PC 8 is counted.
4. In HALT, redirect to 0 -> state FETCH, halted=0, word 0 delivered again, inst_count continues from 4 to 5.
5. Redirect to 6, then separately to 16 -> fault=1, inst_valid=0, no fetch. Later start and redirect are ignored. Reset clears fault.
6. Reset asserted mid-stream with inst_valid=1 -> all outputs go to reset values immediately without waiting for a clock edge, and pc returns to RESET_PC.
